// File: rtl/core_launcher.sv
// -----------------------------------------------------------------------------
// core_launcher
//   Host-side sequencer for an N-core matrix-multiply array. A host start
//   holds the selected cores in reset for CLR_CYCLES cycles. It then sends a
//   one-cycle launch pulse on status_o and collects the per-core end_process
//   flags while it counts run cycles. The run ends in DONE when every enabled
//   core has finished, or in ERR when the cycle budget runs out first.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-high
//   start          host launch request (honoured in IDLE/DONE/ERR only)
//   core_en        cores taking part in the run, latched on an accepted start
//   timeout_limit  maximum RUN cycles, 0 disables the timeout
//   end_process_i  per-core end flag (level)
//   core_rst_o     per-core reset to the control units/datapaths
//   status_o       per-core launch pulse
//   busy           high in CLEAR, LAUNCH and RUN
//   done           high in DONE
//   timeout_err    high in ERR
//   cores_done     sticky per-core completion flags of the current run
//   cycle_count    RUN-cycle count of the current/last run (saturating)
// -----------------------------------------------------------------------------
module core_launcher #(
   parameter int N_CORES    = 4,
   parameter int CNT_W      = 24,
   parameter int CLR_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_CORES-1:0] core_en,
   input  logic [CNT_W-1:0]   timeout_limit,
   input  logic [N_CORES-1:0] end_process_i,
   output logic [N_CORES-1:0] core_rst_o,
   output logic [N_CORES-1:0] status_o,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic [N_CORES-1:0] cores_done,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LAUNCH,
      S_RUN,
      S_DONE,
      S_ERR
   } state_e;

   state_e             state_q;
   logic [N_CORES-1:0] en_q;
   logic [CLR_W-1:0]   clr_cnt_q;
   logic [N_CORES-1:0] core_rst_q;
   logic [N_CORES-1:0] status_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic [N_CORES-1:0] cores_done_q;
   logic [CNT_W-1:0]   cycle_count_q;

   // Next-state helpers for the RUN state.
   logic [N_CORES-1:0] cores_done_d;
   logic [CNT_W-1:0]   cycle_count_d;
   logic               all_done_d;
   logic               timeout_hit_d;

   // cores_done only ever gains bits that are inside en_q, so a run is
   // complete exactly when the merged flags equal the enable mask. This
   // includes flags sampled in this very cycle.
   assign cores_done_d  = cores_done_q | (end_process_i & en_q);
   assign all_done_d    = (cores_done_d == en_q);
   assign timeout_hit_d = (timeout_limit != '0) && (cycle_count_q == timeout_limit);
   assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);

   // NOTE: every register in this block uses non-blocking assignment. Each
   // branch then reads the pre-edge value of all state, whatever the order
   // in which the statements are written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         en_q          <= '0;
         clr_cnt_q     <= '0;
         core_rst_q    <= '1;
         status_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         cores_done_q  <= '0;
         cycle_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  en_q          <= core_en;
                  cores_done_q  <= '0;
                  cycle_count_q <= '0;
                  clr_cnt_q     <= '0;
                  err_q         <= 1'b0;
                  if (core_en == '0) begin
                     // Empty run: report completion at once and leave the cores alone.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     // Cores that are not enabled keep their current reset level.
                     state_q    <= S_CLEAR;
                     core_rst_q <= core_rst_q | core_en;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                  end
               end
            end

            S_CLEAR: begin
               if (clr_cnt_q == CLR_LAST) begin
                  state_q    <= S_LAUNCH;
                  core_rst_q <= core_rst_q & ~en_q;
                  status_q   <= en_q;
               end else begin
                  clr_cnt_q <= clr_cnt_q + CLR_W'(1);
               end
            end

            S_LAUNCH: begin
               state_q       <= S_RUN;
               status_q      <= '0;
               cycle_count_q <= CNT_W'(1);
            end

            S_RUN: begin
               cores_done_q <= cores_done_d;
               if (all_done_d) begin
                  // Completion takes priority over a timeout in the same cycle.
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (timeout_hit_d) begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cycle_count_q <= cycle_count_d;
               end
            end

            default: begin
               state_q  <= S_IDLE;
               status_q <= '0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               err_q    <= 1'b0;
            end
         endcase
      end
   end

   assign core_rst_o  = core_rst_q;
   assign status_o    = status_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = err_q;
   assign cores_done  = cores_done_q;
   assign cycle_count = cycle_count_q;

endmodule
